// File: rtl/decode_pkg.sv
// Shared types for the decode stage: instruction format enum, base opcodes,
// the registered slot record and the opcode-to-format classifier.
package decode_pkg;

   // Instruction format derived purely from the opcode.
   typedef enum logic [2:0] {
      ITYPE_NONE = 3'd0,
      ITYPE_R    = 3'd1,
      ITYPE_I    = 3'd2,
      ITYPE_S    = 3'd3,
      ITYPE_SB   = 3'd4,
      ITYPE_U    = 3'd5,
      ITYPE_UJ   = 3'd6
   } itype_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Width-independent slot fields; PC and immediate are held beside this
   // record because their widths follow the module parameters.
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] func3;
      logic [6:0] func7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      itype_e     itype;
      logic       rd_we;
      logic       rs1_used;
      logic       rs2_used;
   } decoded_t;

   // Map a 7-bit opcode onto its encoding format; anything unrecognised is NONE.
   function automatic itype_e opcode_fmt(input logic [6:0] opc);
      itype_e fmt;
      case (opc)
         OPC_OP:                                   fmt = ITYPE_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = ITYPE_I;
         OPC_STORE:                                fmt = ITYPE_S;
         OPC_BRANCH:                               fmt = ITYPE_SB;
         OPC_LUI, OPC_AUIPC:                       fmt = ITYPE_U;
         OPC_JAL:                                  fmt = ITYPE_UJ;
         default:                                  fmt = ITYPE_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: assembles the format-specific immediate as a 32-bit
// value, then sign-extends it to XLEN. R and NONE formats yield zero.
module decode_imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  itype_e          itype_i,
   output logic [XLEN-1:0] immed_o
);

   logic [31:0] imm32;
   logic        unused_opc;

   // Opcode bits never contribute to an immediate.
   assign unused_opc = ^instr_i[6:0];

   // Scatter-gather of immediate bits per format, sign taken from instr[31].
   always_comb begin
      imm32 = '0;
      case (itype_i)
         ITYPE_I:  imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         ITYPE_S:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         ITYPE_SB: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
         ITYPE_U:  imm32 = {instr_i[31:12], 12'b0};
         ITYPE_UJ: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
         default:  imm32 = '0;
      endcase
   end

   // Signed size cast replicates bit 31 up to XLEN (no-op when XLEN is 32).
   assign immed_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32/RV64 integer decode stage: opcode-driven format classification,
// field gating, immediate generation and a single valid/ready output slot
// with stall and flush. Optional illegal-instruction flag under the macro
// DECODE_ILLEGAL_EN (adds the illegal_o port when defined).
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = XLEN
) (
   input  logic            clk_i,
   input  logic            DECrst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [PC_W-1:0] pc_o,
   output logic [6:0]      opcode_o,
   output logic [2:0]      func3_o,
   output logic [6:0]      func7_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] immed_o,
   output itype_e          itype_o,
   output logic            rd_we_o,
   output logic            rs1_used_o,
   output logic            rs2_used_o
`ifdef DECODE_ILLEGAL_EN
   ,
   output logic            illegal_o
`endif
);

   itype_e          fmt_raw;
   itype_e          fmt;
   decoded_t        dec_d, slot_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [PC_W-1:0] pc_q;
   logic            valid_q;
   logic            accept;
   logic            has_rd, has_rs1, has_rs2;

   assign fmt_raw = opcode_fmt(instr_i[6:0]);

`ifdef DECODE_ILLEGAL_EN
   logic illegal_d, illegal_q;

   // Illegal encodings are forced to NONE so they carry no side effects.
   always_comb begin
      illegal_d = 1'b0;
      if (instr_i[1:0] != 2'b11)
         illegal_d = 1'b1;
      if (fmt_raw == ITYPE_NONE)
         illegal_d = 1'b1;
      if (fmt_raw == ITYPE_R && instr_i[31:25] != 7'b0000000 && instr_i[31:25] != 7'b0100000)
         illegal_d = 1'b1;
      if (fmt_raw == ITYPE_SB && (instr_i[14:12] == 3'b010 || instr_i[14:12] == 3'b011))
         illegal_d = 1'b1;
      if (fmt_raw == ITYPE_S && instr_i[14:12] > 3'b010)
         illegal_d = 1'b1;
   end

   assign fmt = illegal_d ? ITYPE_NONE : fmt_raw;

   // Illegal flag travels with the slot and obeys the same load enable.
   always_ff @(posedge clk_i or negedge DECrst_i) begin
      if (!DECrst_i)
         illegal_q <= 1'b0;
      else if (accept)
         illegal_q <= illegal_d;
   end

   assign illegal_o = illegal_q;
`else
   assign fmt = fmt_raw;
`endif

   assign has_rd  = fmt inside {ITYPE_R, ITYPE_I, ITYPE_U, ITYPE_UJ};
   assign has_rs1 = fmt inside {ITYPE_R, ITYPE_I, ITYPE_S, ITYPE_SB};
   assign has_rs2 = fmt inside {ITYPE_R, ITYPE_S, ITYPE_SB};

   // Field extraction with every format-undefined field forced to zero.
   always_comb begin
      dec_d          = '0;
      dec_d.opcode   = instr_i[6:0];
      dec_d.func3    = has_rs1 ? instr_i[14:12] : 3'd0;
      dec_d.func7    = (fmt == ITYPE_R) ? instr_i[31:25] : 7'd0;
      dec_d.rs1      = has_rs1 ? instr_i[19:15] : 5'd0;
      dec_d.rs2      = has_rs2 ? instr_i[24:20] : 5'd0;
      dec_d.rd       = has_rd ? instr_i[11:7] : 5'd0;
      dec_d.itype    = fmt;
      dec_d.rd_we    = has_rd && (instr_i[11:7] != 5'd0);
      dec_d.rs1_used = has_rs1;
      dec_d.rs2_used = has_rs2;
   end

   decode_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr_i (instr_i),
      .itype_i (fmt),
      .immed_o (imm_d)
   );

   assign in_ready_o = !flush_i && (!valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   // Output slot: flush kills, accept loads, consume-without-refill drains.
   always_ff @(posedge clk_i or negedge DECrst_i) begin
      if (!DECrst_i) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         slot_q  <= '0;
         imm_q   <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         slot_q  <= dec_d;
         imm_q   <= imm_d;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign pc_o        = pc_q;
   assign opcode_o    = slot_q.opcode;
   assign func3_o     = slot_q.func3;
   assign func7_o     = slot_q.func7;
   assign rs1_o       = slot_q.rs1;
   assign rs2_o       = slot_q.rs2;
   assign rd_o        = slot_q.rd;
   assign immed_o     = imm_q;
   assign itype_o     = slot_q.itype;
   assign rd_we_o     = slot_q.rd_we;
   assign rs1_used_o  = slot_q.rs1_used;
   assign rs2_used_o  = slot_q.rs2_used;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage at XLEN=64: stimulus pushes expected
// slot records, a negedge monitor pops and compares on each handshake.
module tb_decode_stage;
   import decode_pkg::*;

   localparam int XLEN = 64;

   typedef struct packed {
      logic [63:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] immed;
      logic [2:0]  itype;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
      logic        ill;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        DECrst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] instr_i = '0;
   logic [63:0] pc_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [63:0] pc_o;
   logic [6:0]  opcode_o;
   logic [2:0]  func3_o;
   logic [6:0]  func7_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [63:0] immed_o;
   itype_e      itype_o;
   logic        rd_we_o, rs1_used_o, rs2_used_o;
`ifdef DECODE_ILLEGAL_EN
   logic        illegal_o;
   localparam logic ILL_ON = 1'b1;
`else
   localparam logic ILL_ON = 1'b0;
`endif

   decode_stage #(.XLEN(XLEN)) dut (
      .clk_i       (clk_i),
      .DECrst_i    (DECrst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .instr_i     (instr_i),
      .pc_i        (pc_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .pc_o        (pc_o),
      .opcode_o    (opcode_o),
      .func3_o     (func3_o),
      .func7_o     (func7_o),
      .rs1_o       (rs1_o),
      .rs2_o       (rs2_o),
      .rd_o        (rd_o),
      .immed_o     (immed_o),
      .itype_o     (itype_o),
      .rd_we_o     (rd_we_o),
      .rs1_used_o  (rs1_used_o),
      .rs2_used_o  (rs2_used_o)
`ifdef DECODE_ILLEGAL_EN
      ,
      .illegal_o   (illegal_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int   total = 0;
   int   bad = 0;
   int   n_in = 0;
   int   n_out = 0;
   exp_t sb_q[$];
   exp_t snap;
   logic stall_prev = 1'b0;

   function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] ins,
                               input itype_e it, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [63:0] imm, input logic we, input logic u1,
                               input logic u2, input logic ill);
      exp_t e;
      e.pc = pc; e.opcode = ins[6:0]; e.func3 = f3; e.func7 = f7;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.immed = imm; e.itype = it;
      e.rd_we = we; e.rs1_used = u1; e.rs2_used = u2; e.ill = ill;
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t a;
      a.pc = pc_o; a.opcode = opcode_o; a.func3 = func3_o; a.func7 = func7_o;
      a.rs1 = rs1_o; a.rs2 = rs2_o; a.rd = rd_o; a.immed = immed_o; a.itype = itype_o;
      a.rd_we = rd_we_o; a.rs1_used = rs1_used_o; a.rs2_used = rs2_used_o;
`ifdef DECODE_ILLEGAL_EN
      a.ill = illegal_o;
`else
      a.ill = 1'b0;
`endif
      return a;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic chk_slot(input string name, input exp_t act, input exp_t req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s pc=%h: got itype=%0d rd=%0d rs1=%0d rs2=%0d imm=%h raw=%h expected itype=%0d rd=%0d rs1=%0d rs2=%0d imm=%h raw=%h",
                  name, req.pc, act.itype, act.rd, act.rs1, act.rs2, act.immed, act,
                  req.itype, req.rd, req.rs1, req.rs2, req.immed, req);
      end else if (name == "slot") begin
         $display("txn pc=%h op=%b itype=%0d rd=%0d imm=%h ok", act.pc, act.opcode, act.itype, act.rd, act.immed);
      end
   endtask

   // Monitor: pop-and-compare on each output handshake, and hold-check while stalled.
   task automatic monitor_step();
      exp_t act;
      if (!DECrst_i) begin
         stall_prev = 1'b0;
      end else begin
         act = sample();
         if (stall_prev && out_valid_o)
            chk_slot("stall_stable", act, snap);
         if (out_valid_o && out_ready_i && !flush_i) begin
            n_out++;
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: got pc=%h expected no output", pc_o);
            end else begin
               chk_slot("slot", act, sb_q.pop_front());
            end
         end
         stall_prev = out_valid_o && !out_ready_i;
         snap = act;
      end
   endtask

   always @(negedge clk_i) monitor_step();

   // Present one instruction and hold it until accepted (bounded); pushes expectation.
   task automatic send(input logic [31:0] ins, input logic [63:0] pc, input exp_t e, output int waits);
      in_valid_i = 1'b1; instr_i = ins; pc_i = pc; waits = 0;
      @(negedge clk_i);
      while (!in_ready_o && waits < 40) begin
         waits++;
         @(negedge clk_i);
      end
      if (in_ready_o) begin
         sb_q.push_back(e);
         n_in++;
      end else begin
         total++; bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 for pc=%h", pc);
      end
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((sb_q.size() != 0 || out_valid_o) && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 50) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      end
      @(posedge clk_i); #1;
   endtask

   localparam logic [31:0] I_ADDI = 32'hFFF00093;
   localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
   localparam logic [31:0] I_LUI  = 32'h123452B7;
   localparam logic [31:0] I_LUIN = 32'h800002B7;
   localparam logic [31:0] I_SUB  = 32'h40208033;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SW   = 32'h0020A423;
   localparam logic [31:0] I_JAL  = 32'hFF9FF0EF;
   localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
   localparam logic [31:0] I_ZERO = 32'h00000000;
   localparam logic [31:0] I_BADR = 32'h42000033;

   function automatic exp_t e_addi(input logic [63:0] pc);
      return mk(pc, I_ADDI, ITYPE_I, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0);
   endfunction
   function automatic exp_t e_add(input logic [63:0] pc);
      return mk(pc, I_ADD, ITYPE_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1, 1, 1, 0);
   endfunction
   function automatic exp_t e_sw(input logic [63:0] pc);
      return mk(pc, I_SW, ITYPE_S, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 64'd8, 0, 1, 1, 0);
   endfunction
   function automatic exp_t e_lui(input logic [63:0] pc);
      return mk(pc, I_LUI, ITYPE_U, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 64'h0000_0000_1234_5000, 1, 0, 0, 0);
   endfunction
   function automatic exp_t e_jal(input logic [63:0] pc);
      return mk(pc, I_JAL, ITYPE_UJ, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0);
   endfunction

   initial begin
      int   w;
      exp_t dropped;
      exp_t e_badr;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_itype", itype_o, 0);
      chk("rst_immed", immed_o, 0);
      chk("rst_pc", pc_o, 0);
      DECrst_i = 1'b1;
      #1 chk("rst_in_ready", in_ready_o, 1);
      @(posedge clk_i); #1;

      // First instruction: one-cycle latency
      send(I_ADDI, 64'h1000, e_addi(64'h1000), w);
      chk("addi_wait", w, 0);
      @(negedge clk_i);
      chk("latency_valid", out_valid_o, 1);
      @(posedge clk_i); #1;

      // Format coverage, back-to-back at full rate
      send(I_BEQ, 64'h1004, mk(64'h1004, I_BEQ, ITYPE_SB, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0,
                               64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0), w);
      chk("beq_wait", w, 0);
      send(I_LUI, 64'h1008, e_lui(64'h1008), w);
      send(I_LUIN, 64'h100C, mk(64'h100C, I_LUIN, ITYPE_U, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5,
                                64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0), w);
      send(I_SUB, 64'h1010, mk(64'h1010, I_SUB, ITYPE_R, 3'd0, 7'h20, 5'd1, 5'd2, 5'd0,
                               64'd0, 0, 1, 1, 0), w);
      send(I_ADD, 64'h1014, e_add(64'h1014), w);
      send(I_SW, 64'h1018, e_sw(64'h1018), w);
      send(I_JAL, 64'h101C, e_jal(64'h101C), w);
      send(I_ONES, 64'h1020, mk(64'h1020, I_ONES, ITYPE_NONE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                                64'd0, 0, 0, 0, ILL_ON), w);
      send(I_ZERO, 64'h1024, mk(64'h1024, I_ZERO, ITYPE_NONE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                                64'd0, 0, 0, 0, ILL_ON), w);
`ifdef DECODE_ILLEGAL_EN
      e_badr = mk(64'h1028, I_BADR, ITYPE_NONE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0, 0, 0, 1);
`else
      e_badr = mk(64'h1028, I_BADR, ITYPE_R, 3'd0, 7'h21, 5'd0, 5'd0, 5'd0, 64'd0, 0, 1, 1, 0);
`endif
      send(I_BADR, 64'h1028, e_badr, w);
      chk("stream_rate", w, 0);
      wait_drain();

      // Four-instruction stream with a three-cycle downstream stall
      send(I_ADD, 64'h2000, e_add(64'h2000), w);
      chk("strm_a_wait", w, 0);
      send(I_SW, 64'h2004, e_sw(64'h2004), w);
      chk("strm_b_wait", w, 0);
      out_ready_i = 1'b0;
      fork
         send(I_LUI, 64'h2008, e_lui(64'h2008), w);
         begin
            repeat (3) begin
               @(negedge clk_i);
               chk("stall_in_ready", in_ready_o, 0);
            end
            @(posedge clk_i); #1;
            out_ready_i = 1'b1;
         end
      join
      chk("strm_c_wait", w, 3);
      send(I_JAL, 64'h200C, e_jal(64'h200C), w);
      chk("strm_d_wait", w, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("drain_valid", out_valid_o, 0);
      chk("drain_hold_rd", rd_o, 1);
      chk("drain_hold_imm", immed_o, 64'hFFFF_FFFF_FFFF_FFF8);
      wait_drain();

      // Flush with a stalled slot and a new instruction offered
      send(I_ADD, 64'h3000, e_add(64'h3000), w);
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; instr_i = I_SW; pc_i = 64'h3004; flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_in_ready", in_ready_o, 0);
      chk("flush_held_valid", out_valid_o, 1);
      @(posedge clk_i); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      dropped = sb_q.pop_front();
      n_in--;
      @(negedge clk_i);
      chk("flush_kill", out_valid_o, 0);
      @(negedge clk_i);
      chk("flush_drop", out_valid_o, 0);
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;

      // Asynchronous reset in the middle of a stall
      send(I_ADDI, 64'h4000, e_addi(64'h4000), w);
      out_ready_i = 1'b0;
      @(negedge clk_i);
      chk("pre_rst_valid", out_valid_o, 1);
      #2 DECrst_i = 1'b0;
      #1;
      chk("arst_valid", out_valid_o, 0);
      chk("arst_pc", pc_o, 0);
      chk("arst_imm", immed_o, 0);
      chk("arst_fields", {opcode_o, rd_o, rs1_o, itype_o, rd_we_o, rs1_used_o}, 0);
      sb_q.delete();
      n_in--;
      @(negedge clk_i);
      DECrst_i = 1'b1;
      #1 chk("post_rst_ready", in_ready_o, 1);
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;

      // Recovery after reset
      send(I_JAL, 64'h5000, e_jal(64'h5000), w);
      chk("recover_wait", w, 0);
      wait_drain();
      chk("count", n_out, n_in);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined RV32/RV64 integer decode stage between fetch and register-read/execute.
- Derives the instruction format from the opcode itself, so no per-type enable inputs are needed.
- Generates sign-extended XLEN immediates and register-usage flags.
- Registers all results in one valid/ready pipeline slot with stall and flush support.

Parameters:
- XLEN, 32, datapath/immediate/PC width; legal values 32 or 64.
- PC_W, XLEN, width of the PC carried alongside the instruction.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- DECrst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous kill of the held and incoming instruction.
- in_valid_i  input  1  fetch presents an instruction.
- in_ready_o  output  1  decode can accept this cycle.
- instr_i  input  32  raw instruction.
- pc_i  input  PC_W  PC of instr_i.
- out_valid_o  output  1  decoded slot valid.
- out_ready_i  input  1  downstream accepts the slot.
- pc_o  output  PC_W  registered PC.
- opcode_o  output  7  instr[6:0].
- func3_o  output  3  instr[14:12], or 0 when the format has none.
- func7_o  output  7  instr[31:25] for R-type, else 0.
- rs1_o, rs2_o, rd_o  output  5 each  register indices, or 0 when unused.
- immed_o  output  XLEN  sign-extended immediate.
- itype_o  output  3  itype_e: NONE, R, I, S, SB, U, UJ.
- rd_we_o  output  1  writes rd, and rd != 0.
- rs1_used_o, rs2_used_o  output  1 each  source-operand use flags.
- illegal_o  output  1  present only with DECODE_ILLEGAL_EN.

Behaviour:
- Reset (DECrst_i low, asynchronous): every output register clears to 0.
  - out_valid_o=0, itype_o=NONE.
  - in_ready_o=1 once reset is released.
- Format map by opcode:
  - 0110011 R.
  - 0010011, 0000011, 1100111, 1110011 I.
  - 0100011 S.
  - 1100011 SB.
  - 0110111, 0010111 U.
  - 1101111 UJ.
  - Any other opcode NONE.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - SB: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - UJ: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and NONE: 0.
- Field gating:
  - Fields not defined by the format are driven 0. Every path assigns every field, so no latches are inferred.
  - rd_we = (R|I|U|UJ) and rd != 0.
  - rs1_used = R|I|S|SB; rs2_used = R|S|SB.
  - U-type LUI vs AUIPC is distinguished downstream via opcode_o.
- Handshake:
  - in_ready_o = !flush_i && (!out_valid_o || out_ready_i).
  - Accept when in_valid_i && in_ready_o: the slot loads the decode result and out_valid_o=1 next cycle.
  - Latency 1 cycle; sustained throughput 1 instruction/cycle.
  - Stall: while out_valid_o && !out_ready_i, every output stays bit-stable.
  - Drain: if the slot is consumed and nothing is accepted, out_valid_o=0 next cycle; data outputs keep their last values.
- Flush:
  - flush_i=1 means out_valid_o=0 next cycle, regardless of out_ready_i or in_valid_i.
  - The incoming instruction is dropped, and fetch must not see a handshake that cycle.
  - Flush has priority over a simultaneous accept.
- Reset mid-stall: the slot is discarded immediately, with no completion.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined: illegal_o exists and is registered with the slot. It is set when any of these hold:
  - instr[1:0] != 11.
  - Unknown opcode.
  - R-type with func7 not 0000000 or 0100000.
  - SB-type with func3 010 or 011.
  - S-type with func3 > 010.
  - An illegal instruction still flows through the handshake with itype_o=NONE, rd_we_o=0 and both use flags 0.
- Undefined: no illegal_o port. An unknown opcode yields itype_o=NONE with all fields 0 except pc_o and opcode_o, and it still flows through.

Decomposition:
- Shared package decode_pkg holds:
  - itype_e enum.
  - Opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL).
  - decoded_t struct of all slot fields.
- One combinational sub-module, decode_imm_gen: instr plus itype in, XLEN immediate out.
- decode_stage contains the format classifier, field gating and the pipeline slot.

Test Plan:
- Reset, then 0xFFF00093 (addi x1,x0,-1) with out_ready_i=1 -> next cycle: out_valid_o=1, itype I, rd_o=1, rs1_o=0, immed_o=0xFFFFFFFF, rd_we_o=1, rs2_used_o=0.
- 0xFE208EE3 (beq x1,x2,-4) -> itype SB, rs1_o=1, rs2_o=2, immed_o=0xFFFFFFFC, rd_o=0, rd_we_o=0.
- 0x123452B7 (lui x5,0x12345) with XLEN=64 -> immed_o=0x0000000012345000, rd_o=5. Then 0x800002B7 -> immed_o=0xFFFFFFFF80000000.
- Back-to-back stream of 4 instructions, with out_ready_i low for 3 cycles mid-stream -> in_ready_o=0 and outputs stable during the stall, no instruction lost or duplicated, full rate before and after.
- flush_i with a valid stalled slot and in_valid_i=1 -> in_ready_o=0 that cycle, out_valid_o=0 next cycle. Assert DECrst_i low mid-stall -> all outputs 0 asynchronously.
- With DECODE_ILLEGAL_EN, 0x00000000 and 0x4200_0033 (func7=0100001) -> illegal_o=1, itype NONE, rd_we_o=0. 0x40208033 (sub) -> illegal_o=0, func7_o=0x20.
